// File: rtl/uart_frame_assembler.sv
// Packs NUM_INPUTS received UART bytes into one flat frame and offers it with valid/ready.
// Optional trailing XOR checksum byte when the CHECKSUM_EN macro is defined.
module uart_frame_assembler #(
    parameter int unsigned NUM_INPUTS     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 160,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [NUM_INPUTS*8-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err,
    output logic                    overrun,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StCollect, StCheck, StHold} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;
`endif

    state_e                  r_state, w_state_d;
    logic [IDX_W-1:0]        r_idx, w_idx_d;
    logic [CNT_W-1:0]        r_timer, w_timer_d;
    logic [NUM_INPUTS*8-1:0] r_frame_data, w_frame_data_d;
    logic                    r_frame_err, w_frame_err_d;
    logic                    r_overrun, w_overrun_d;
    logic                    w_take;
`ifdef CHECKSUM_EN
    logic [7:0]              r_csum, w_csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_timer      <= '0;
            r_frame_data <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_timer      <= w_timer_d;
            r_frame_data <= w_frame_data_d;
            r_frame_err  <= w_frame_err_d;
            r_overrun    <= w_overrun_d;
`ifdef CHECKSUM_EN
            r_csum       <= w_csum_d;
`endif
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_timer_d      = r_timer;
        w_frame_data_d = r_frame_data;
        w_frame_err_d  = 1'b0;
        w_overrun_d    = 1'b0;
        w_take         = 1'b0;
`ifdef CHECKSUM_EN
        w_csum_d       = r_csum;
`endif

        unique case (r_state)
            StIdle: begin
                w_take = rx_valid;
            end
            StCollect: begin
                if (rx_valid) begin
                    w_take = 1'b1;
                end else if (r_timer == TIMER_MAX) begin
                    w_frame_err_d = 1'b1;
                    w_idx_d       = '0;
                    w_timer_d     = '0;
                    w_state_d     = StIdle;
                end else begin
                    w_timer_d = r_timer + CNT_W'(1);
                end
            end
`ifdef CHECKSUM_EN
            StCheck: begin
                if (rx_valid) begin
                    w_timer_d = '0;
                    if (rx_data == r_csum) begin
                        w_state_d = StHold;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = StIdle;
                    end
                end else if (r_timer == TIMER_MAX) begin
                    w_frame_err_d = 1'b1;
                    w_timer_d     = '0;
                    w_state_d     = StIdle;
                end else begin
                    w_timer_d = r_timer + CNT_W'(1);
                end
            end
`endif
            StHold: begin
                // A byte landing on the handshake cycle starts the next frame.
                if (frame_ready) begin
                    w_state_d = StIdle;
                    w_take    = rx_valid;
                end else if (rx_valid) begin
                    w_overrun_d = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_take) begin
            for (int k = 0; k < int'(NUM_INPUTS); k++) begin
                if (k == int'(r_idx)) begin
                    w_frame_data_d[8*k +: 8] = rx_data;
                end
            end
`ifdef CHECKSUM_EN
            w_csum_d = (r_idx == '0) ? rx_data : (r_csum ^ rx_data);
`endif
            w_timer_d = '0;
            if (r_idx == LAST_IDX) begin
                w_idx_d   = '0;
`ifdef CHECKSUM_EN
                w_state_d = StCheck;
`else
                w_state_d = StHold;
`endif
            end else begin
                w_idx_d   = r_idx + IDX_W'(1);
                w_state_d = StCollect;
            end
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = (r_state == StHold);
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state != StIdle);

endmodule
